bias_bank: RTL and testbench

BIAS_BANK -- requirements
Module: bias_bank

---
 rtl/bias_bank.sv | 138 +++++++++++++
 tb/tb_bias_bank.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bias_bank.sv
// bias_bank: register-file bias store that returns one N_ADDER_TREE-wide vector per accepted fetch.
// Defining BIAS_BANK_RDBACK_EN adds a registered single-word readback port (rb_addr/rb_data).

module bias_bank #(
    parameter int N_ADDER_TREE = 16,
    parameter int DATA_W       = 18,
    parameter int N_GROUPS     = 8,
    localparam int N_WORDS     = N_GROUPS * N_ADDER_TREE,
    localparam int AW          = (N_WORDS > 1) ? $clog2(N_WORDS) : 1,
    localparam int GW          = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           ld_valid,
    input  logic [AW-1:0]                  ld_addr,
    input  logic [DATA_W-1:0]              ld_data,
    input  logic                           fetch_valid,
    input  logic [GW-1:0]                  fetch_group,
    output logic                           fetch_ready,
    output logic                           q_valid,
    input  logic                           q_ready,
    output logic [N_ADDER_TREE*DATA_W-1:0] q,
    output logic                           q_err
`ifdef BIAS_BANK_RDBACK_EN
    ,
    input  logic [AW-1:0]                  rb_addr,
    output logic [DATA_W-1:0]              rb_data
`endif
);
    localparam int LW = (N_ADDER_TREE > 1) ? $clog2(N_ADDER_TREE) : 1;

    typedef struct packed {
        logic                                   err;
        logic [N_ADDER_TREE-1:0][DATA_W-1:0]    vec;
    } rsp_t;

    logic [N_ADDER_TREE-1:0][N_GROUPS-1:0][DATA_W-1:0] all_words;

    logic          ld_ok;
    logic [GW-1:0] ld_grp;
    logic [LW-1:0] ld_lane;

    // Extra MSB keeps the range check correct when N_WORDS is an exact power of two.
    assign ld_ok   = {1'b0, ld_addr} < (AW+1)'(N_WORDS);
    assign ld_grp  = GW'(ld_addr / AW'(N_ADDER_TREE));
    assign ld_lane = LW'(ld_addr % AW'(N_ADDER_TREE));

    for (genvar l = 0; l < N_ADDER_TREE; l++) begin : g_lane
        bias_bank_lane #(
            .DATA_W   (DATA_W),
            .N_GROUPS (N_GROUPS),
            .GW       (GW)
        ) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .wr_en   (ld_valid && ld_ok && (ld_lane == LW'(l))),
            .wr_grp  (ld_grp),
            .wr_data (ld_data),
            .words   (all_words[l])
        );
    end

    rsp_t fetch_rsp;
    rsp_t q_r;
    logic fetch_ok;
    logic accept;

    assign fetch_ok    = {1'b0, fetch_group} < (GW+1)'(N_GROUPS);
    assign fetch_ready = !q_valid || q_ready;
    assign accept      = fetch_valid && fetch_ready;

    // Reads the pre-edge storage, so a same-cycle load to this group is not visible yet.
    always_comb begin
        fetch_rsp     = '0;
        fetch_rsp.err = !fetch_ok;
        if (fetch_ok) begin
            for (int l = 0; l < N_ADDER_TREE; l++)
                fetch_rsp.vec[l] = all_words[l][fetch_group];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r     <= '0;
            q_valid <= 1'b0;
        end else if (accept) begin
            q_r     <= fetch_rsp;
            q_valid <= 1'b1;
        end else if (q_ready) begin
            q_valid <= 1'b0;
        end
    end

    assign q     = q_r.vec;
    assign q_err = q_r.err;

`ifdef BIAS_BANK_RDBACK_EN
    logic          rb_ok;
    logic [GW-1:0] rb_grp;
    logic [LW-1:0] rb_lane;

    assign rb_ok   = {1'b0, rb_addr} < (AW+1)'(N_WORDS);
    assign rb_grp  = GW'(rb_addr / AW'(N_ADDER_TREE));
    assign rb_lane = LW'(rb_addr % AW'(N_ADDER_TREE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     rb_data <= '0;
        else if (rb_ok) rb_data <= all_words[rb_lane][rb_grp];
        else            rb_data <= '0;
    end
`else
    // Storage is observable only through the fetch path in this build.
`endif

endmodule

// One bias lane: N_GROUPS words, one per channel group, written by decoded strobe.
module bias_bank_lane #(
    parameter int DATA_W   = 18,
    parameter int N_GROUPS = 8,
    parameter int GW       = 3
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            wr_en,
    input  logic [GW-1:0]                   wr_grp,
    input  logic [DATA_W-1:0]               wr_data,
    output logic [N_GROUPS-1:0][DATA_W-1:0] words
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            words <= '0;
        end else begin
            for (int g = 0; g < N_GROUPS; g++)
                if (wr_en && (wr_grp == GW'(g))) words[g] <= wr_data;
        end
    end
endmodule

// File: tb/tb_bias_bank.sv
// Self-checking bench for bias_bank: directed scenarios plus a randomized run against a word-array model.
// A second instance with N_GROUPS=5 exercises out-of-range fetches and loads.
module tb_bias_bank;
    localparam int NL  = 16;
    localparam int DW  = 18;
    localparam int NG  = 8;
    localparam int NG5 = 5;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          ld_valid, fetch_valid, fetch_ready, q_valid, q_ready, q_err;
    logic [6:0]    ld_addr;
    logic [DW-1:0] ld_data;
    logic [2:0]    fetch_group;
    logic [NL*DW-1:0] q;

    logic          ld_valid5, fetch_valid5, fetch_ready5, q_valid5, q_ready5, q_err5;
    logic [6:0]    ld_addr5;
    logic [DW-1:0] ld_data5;
    logic [2:0]    fetch_group5;
    logic [NL*DW-1:0] q5;

`ifdef BIAS_BANK_RDBACK_EN
    logic [6:0]    rb_addr, rb_addr5;
    logic [DW-1:0] rb_data, rb_data5;
`endif

    bias_bank #(.N_ADDER_TREE(NL), .DATA_W(DW), .N_GROUPS(NG)) dut (
        .clk(clk), .rst_n(rst_n),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
        .fetch_valid(fetch_valid), .fetch_group(fetch_group), .fetch_ready(fetch_ready),
        .q_valid(q_valid), .q_ready(q_ready), .q(q), .q_err(q_err)
`ifdef BIAS_BANK_RDBACK_EN
        , .rb_addr(rb_addr), .rb_data(rb_data)
`endif
    );

    bias_bank #(.N_ADDER_TREE(NL), .DATA_W(DW), .N_GROUPS(NG5)) dut5 (
        .clk(clk), .rst_n(rst_n),
        .ld_valid(ld_valid5), .ld_addr(ld_addr5), .ld_data(ld_data5),
        .fetch_valid(fetch_valid5), .fetch_group(fetch_group5), .fetch_ready(fetch_ready5),
        .q_valid(q_valid5), .q_ready(q_ready5), .q(q5), .q_err(q_err5)
`ifdef BIAS_BANK_RDBACK_EN
        , .rb_addr(rb_addr5), .rb_data(rb_data5)
`endif
    );

    int errors = 0;
    int checks = 0;

    // Reference storage: flat word arrays indexed by load address.
    logic [DW-1:0] mem  [NG*NL];
    logic [DW-1:0] mem5 [NG5*NL];

    function automatic logic [NL*DW-1:0] exp_vec(input int g);
        logic [NL*DW-1:0] v;
        v = '0;
        if (g < NG) for (int l = 0; l < NL; l++) v[l*DW +: DW] = mem[g*NL + l];
        return v;
    endfunction

    function automatic logic [NL*DW-1:0] exp_vec5(input int g);
        logic [NL*DW-1:0] v;
        v = '0;
        if (g < NG5) for (int l = 0; l < NL; l++) v[l*DW +: DW] = mem5[g*NL + l];
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int a = 0; a < NG*NL; a++)  mem[a]  = '0;
        for (int a = 0; a < NG5*NL; a++) mem5[a] = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++; if (q_valid !== 1'b0) begin errors++; $display("FAIL reset_q_valid: got %b want 0", q_valid); end
        checks++; if (q !== '0) begin errors++; $display("FAIL reset_q: got %h want 0", q); end
        checks++; if (q_err !== 1'b0) begin errors++; $display("FAIL reset_q_err: got %b want 0", q_err); end
        checks++; if (fetch_ready !== 1'b1) begin errors++; $display("FAIL reset_fetch_ready: got %b want 1", fetch_ready); end
        tick();
        tick();
        rst_n = 1'b1;
        clear_model();
    endtask

    task automatic test_load_fetch();
        for (int a = 0; a < NG*NL; a++) begin
            ld_valid = 1'b1;
            ld_addr  = 7'(a);
            if (a == 0)      ld_data = 18'h00064;
            else if (a == 1) ld_data = 18'h3F9B0;
            else if (a == 2) ld_data = DW'($urandom) | 18'h00100;
            else             ld_data = DW'($urandom);
            tick();
            mem[a] = ld_data;
        end
        ld_valid    = 1'b0;
        fetch_valid = 1'b1;
        fetch_group = 3'd0;
        q_ready     = 1'b1;
        #1;
        checks++; if (fetch_ready !== 1'b1) begin errors++; $display("FAIL lf_ready: got %b want 1", fetch_ready); end
        tick();
        fetch_valid = 1'b0;
        checks++; if (q_valid !== 1'b1) begin errors++; $display("FAIL lf_q_valid: got %b want 1", q_valid); end
        checks++; if (q[0 +: DW] !== 18'h00064) begin errors++; $display("FAIL lf_lane0: got %h want 00064", q[0 +: DW]); end
        checks++; if (q[DW +: DW] !== 18'h3F9B0) begin errors++; $display("FAIL lf_lane1: got %h want 3f9b0", q[DW +: DW]); end
        checks++; if (q !== exp_vec(0)) begin errors++; $display("FAIL lf_vec: got %h want %h", q, exp_vec(0)); end
        checks++; if (q_err !== 1'b0) begin errors++; $display("FAIL lf_q_err: got %b want 0", q_err); end
        tick();
        checks++; if (q_valid !== 1'b0) begin errors++; $display("FAIL lf_drain: got %b want 0", q_valid); end
    endtask

    task automatic test_stall();
        logic [NL*DW-1:0] hold;
        q_ready     = 1'b0;
        fetch_valid = 1'b1;
        fetch_group = 3'd1;
        hold        = exp_vec(1);
        tick();
        checks++; if (q !== hold) begin errors++; $display("FAIL st_first: got %h want %h", q, hold); end
        for (int c = 0; c < 5; c++) begin
            ld_valid = 1'b1;
            ld_addr  = 7'd16;
            ld_data  = 18'h1FFFF;
            #1;
            checks++; if (fetch_ready !== 1'b0) begin errors++; $display("FAIL st_ready c%0d: got %b want 0", c, fetch_ready); end
            tick();
            mem[16] = 18'h1FFFF;
            checks++; if (q !== hold || q_valid !== 1'b1 || q_err !== 1'b0) begin
                errors++; $display("FAIL st_hold c%0d: got v=%b e=%b q=%h want v=1 e=0 q=%h", c, q_valid, q_err, q, hold);
            end
        end
        ld_valid = 1'b0;
        q_ready  = 1'b1;
        #1;
        checks++; if (fetch_ready !== 1'b1) begin errors++; $display("FAIL st_release: got %b want 1", fetch_ready); end
        tick();
        fetch_valid = 1'b0;
        checks++; if (q[0 +: DW] !== 18'h1FFFF) begin errors++; $display("FAIL st_refetch_lane0: got %h want 1ffff", q[0 +: DW]); end
        checks++; if (q !== exp_vec(1) || q_valid !== 1'b1) begin errors++; $display("FAIL st_refetch: got v=%b q=%h want %h", q_valid, q, exp_vec(1)); end
        tick();
        checks++; if (q_valid !== 1'b0) begin errors++; $display("FAIL st_drain: got %b want 0", q_valid); end
    endtask

    task automatic test_rbw();
        logic [DW-1:0]    old;
        logic [NL*DW-1:0] e;
        old         = mem[2];
        e           = exp_vec(0);
        ld_valid    = 1'b1;
        ld_addr     = 7'd2;
        ld_data     = 18'h00001;
        fetch_valid = 1'b1;
        fetch_group = 3'd0;
        q_ready     = 1'b1;
        tick();
        mem[2]   = 18'h00001;
        ld_valid = 1'b0;
        checks++; if (q[2*DW +: DW] !== old) begin errors++; $display("FAIL rbw_old: got %h want %h", q[2*DW +: DW], old); end
        checks++; if (q !== e) begin errors++; $display("FAIL rbw_vec: got %h want %h", q, e); end
        tick();
        fetch_valid = 1'b0;
        checks++; if (q[2*DW +: DW] !== 18'h00001) begin errors++; $display("FAIL rbw_new: got %h want 00001", q[2*DW +: DW]); end
        tick();
    endtask

    task automatic test_back_to_back();
        q_ready = 1'b1;
        for (int k = 0; k < NG; k++) begin
            fetch_valid = 1'b1;
            fetch_group = 3'(k);
            tick();
            checks++; if (q_valid !== 1'b1 || q !== exp_vec(k)) begin
                errors++; $display("FAIL b2b g%0d: got v=%b q=%h want v=1 q=%h", k, q_valid, q, exp_vec(k));
            end
        end
        for (int k = 0; k < 3; k++) begin
            fetch_group = 3'(k + 3);
            tick();
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (q_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", q_valid); end
        checks++; if (q !== '0 || q_err !== 1'b0) begin errors++; $display("FAIL midrst_q: got %h e=%b want 0", q, q_err); end
        fetch_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        clear_model();
        #1;
        checks++; if (fetch_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b want 1", fetch_ready); end
        for (int k = 0; k < NG; k++) begin
            fetch_valid = 1'b1;
            fetch_group = 3'(k);
            tick();
            checks++; if (q_valid !== 1'b1 || q !== '0) begin errors++; $display("FAIL postrst g%0d: got v=%b q=%h want v=1 q=0", k, q_valid, q); end
        end
        fetch_valid = 1'b0;
        tick();
    endtask

    task automatic test_random();
        logic             ev, rdy;
        logic [NL*DW-1:0] eq;
        ev = 1'b0;
        eq = '0;
        for (int i = 0; i < 300; i++) begin
            ld_valid    = 1'($urandom_range(0, 1));
            ld_addr     = 7'($urandom);
            ld_data     = DW'($urandom);
            fetch_valid = 1'($urandom_range(0, 1));
            fetch_group = 3'($urandom);
            q_ready     = ($urandom_range(0, 3) != 0);
            #1;
            rdy = !ev || q_ready;
            checks++; if (fetch_ready !== rdy) begin errors++; $display("FAIL rnd_ready i%0d: got %b want %b", i, fetch_ready, rdy); end
            if (fetch_valid && rdy) begin
                eq = exp_vec(int'(fetch_group));
                ev = 1'b1;
            end else if (q_ready) begin
                ev = 1'b0;
            end
            tick();
            if (ld_valid) mem[ld_addr] = ld_data;
            checks++; if (q_valid !== ev) begin errors++; $display("FAIL rnd_valid i%0d: got %b want %b", i, q_valid, ev); end
            if (ev) begin
                checks++; if (q !== eq || q_err !== 1'b0) begin errors++; $display("FAIL rnd_q i%0d: got %h e=%b want %h", i, q, q_err, eq); end
            end
        end
        ld_valid    = 1'b0;
        fetch_valid = 1'b0;
        q_ready     = 1'b1;
        tick();
    endtask

    task automatic test_out_of_range();
        for (int a = 0; a < NG5*NL; a++) begin
            ld_valid5 = 1'b1;
            ld_addr5  = 7'(a);
            ld_data5  = DW'($urandom);
            tick();
            mem5[a] = ld_data5;
        end
        ld_valid5    = 1'b0;
        fetch_valid5 = 1'b1;
        fetch_group5 = 3'd6;
        q_ready5     = 1'b1;
        tick();
        fetch_valid5 = 1'b0;
        checks++; if (q5 !== '0 || q_err5 !== 1'b1 || q_valid5 !== 1'b1) begin
            errors++; $display("FAIL oob_g6: got v=%b e=%b q=%h want v=1 e=1 q=0", q_valid5, q_err5, q5);
        end
        ld_valid5 = 1'b1;
        ld_addr5  = 7'd80;
        ld_data5  = 18'h3FFFF;
        tick();
        ld_addr5  = 7'd127;
        tick();
        ld_valid5 = 1'b0;
        for (int g = 0; g < NG; g++) begin
            fetch_valid5 = 1'b1;
            fetch_group5 = 3'(g);
            tick();
            checks++; if (q5 !== exp_vec5(g) || q_err5 !== (g >= NG5)) begin
                errors++; $display("FAIL oob_scan g%0d: got e=%b q=%h want e=%b q=%h", g, q_err5, q5, (g >= NG5), exp_vec5(g));
            end
        end
        fetch_valid5 = 1'b0;
        tick();
    endtask

`ifdef BIAS_BANK_RDBACK_EN
    task automatic test_rdback();
        ld_valid = 1'b1;
        ld_addr  = 7'd5;
        ld_data  = 18'h3FFFE;
        rb_addr  = 7'd5;
        rb_addr5 = 7'd100;
        tick();
        mem[5]   = 18'h3FFFE;
        ld_valid = 1'b0;
        tick();
        checks++; if (rb_data !== 18'h3FFFE) begin errors++; $display("FAIL rb_word: got %h want 3fffe", rb_data); end
        checks++; if (rb_data5 !== '0) begin errors++; $display("FAIL rb_oob: got %h want 0", rb_data5); end
    endtask
`endif

    initial begin
        ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
        fetch_valid = 1'b0; fetch_group = '0; q_ready = 1'b0;
        ld_valid5 = 1'b0; ld_addr5 = '0; ld_data5 = '0;
        fetch_valid5 = 1'b0; fetch_group5 = '0; q_ready5 = 1'b0;
`ifdef BIAS_BANK_RDBACK_EN
        rb_addr = '0; rb_addr5 = '0;
`endif
        test_reset();
        test_load_fetch();
        test_stall();
        test_rbw();
        test_back_to_back();
        test_load_fetch();
        test_random();
        test_out_of_range();
`ifdef BIAS_BANK_RDBACK_EN
        test_rdback();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within bound");
        $fatal(1, "timeout");
    end
endmodule
